// File: rtl/serial_bus_arbiter_pkg.sv
// Shared types and defaults for the serial bus arbiter slice.
package serial_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_NUM_MASTERS = 12;
    localparam int unsigned DEF_MID_WIDTH   = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 16;
    localparam int unsigned DEF_HOLD_MAX    = 1024;
    localparam int unsigned ACK_CNT_W       = 6;

    // Single-step modulo: callers guarantee idx < 2*n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/serial_bus_arbiter_picker.sv
// Rotating-priority picker: lowest requesting index at or above i_ptr, wrapping.
module rr_priority_picker
    import serial_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned MID_WIDTH   = DEF_MID_WIDTH
) (
    input  logic [NUM_MASTERS-1:0] i_reqs,
    input  logic [MID_WIDTH-1:0]   i_ptr,
    output logic [MID_WIDTH-1:0]   o_winner,
    output logic                   o_any
);

    int unsigned            w_idx;
    logic [NUM_MASTERS-1:0] w_shifted;

    always_comb begin
        o_winner  = '0;
        o_any     = 1'b0;
        w_idx     = 0;
        w_shifted = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            w_idx     = rr_wrap(32'(i_ptr) + k, NUM_MASTERS);
            w_shifted = i_reqs >> w_idx;
            if (!o_any && w_shifted[0]) begin
                o_any    = 1'b1;
                o_winner = MID_WIDTH'(w_idx);
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin grant FSM with ack timeout; optional BUSY hold limit
// enabled by defining SERIAL_BUS_ARB_HOLD_LIMIT_EN.
module serial_bus_arbiter
    import serial_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned MID_WIDTH   = DEF_MID_WIDTH,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned HOLD_MAX    = DEF_HOLD_MAX
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_MASTERS-1:0] i_m_reqs,
    input  logic                   i_bus_util,
    output logic [NUM_MASTERS-1:0] o_m_grants,
    output logic [MID_WIDTH-1:0]   o_mid_current,
    output logic                   o_grant_valid,
    output logic [1:0]             o_state,
    output logic                   o_timeout_evt
);

    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 63 || HOLD_MAX < 2 || (1 << MID_WIDTH) < NUM_MASTERS) begin : g_bad_config
        $fatal(1, "serial_bus_arbiter: illegal parameter combination");
    end

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grants;
    logic [MID_WIDTH-1:0]   r_mid;
    logic [MID_WIDTH-1:0]   r_ptr;
    logic [ACK_CNT_W-1:0]   r_ack_cnt;
    logic                   r_gvalid;
    logic                   r_tevt;
`ifdef SERIAL_BUS_ARB_HOLD_LIMIT_EN
    localparam int unsigned HOLD_CNT_W = $clog2(HOLD_MAX);
    logic [HOLD_CNT_W-1:0]  r_hold_cnt;
`endif

    logic [MID_WIDTH-1:0]   w_winner;
    logic                   w_any;
    logic                   w_req_held;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MID_WIDTH   (MID_WIDTH)
    ) u_picker (
        .i_reqs   (i_m_reqs),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_req_held = |(i_m_reqs & r_grants);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_grants  <= '0;
            r_mid     <= '0;
            r_ptr     <= '0;
            r_ack_cnt <= '0;
            r_gvalid  <= 1'b0;
            r_tevt    <= 1'b0;
`ifdef SERIAL_BUS_ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_tevt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A low utilisation line here belongs to someone else; do not grant over it.
                    if (w_any && i_bus_util) begin
                        r_grants  <= NUM_MASTERS'(1) << w_winner;
                        r_mid     <= w_winner;
                        r_gvalid  <= 1'b1;
                        r_ack_cnt <= '0;
                        r_state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!i_bus_util) begin
                        r_state <= ST_BUSY;
`ifdef SERIAL_BUS_ARB_HOLD_LIMIT_EN
                        r_hold_cnt <= '0;
`endif
                    end else if (!w_req_held) begin
                        r_grants <= '0;
                        r_gvalid <= 1'b0;
                        r_state  <= ST_RELEASE;
                    end else if (r_ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                        r_grants <= '0;
                        r_gvalid <= 1'b0;
                        r_tevt   <= 1'b1;
                        r_state  <= ST_RELEASE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (i_bus_util) begin
                        r_grants <= '0;
                        r_gvalid <= 1'b0;
                        r_state  <= ST_RELEASE;
`ifdef SERIAL_BUS_ARB_HOLD_LIMIT_EN
                    end else if (r_hold_cnt == HOLD_CNT_W'(HOLD_MAX - 1)) begin
                        r_grants <= '0;
                        r_gvalid <= 1'b0;
                        r_tevt   <= 1'b1;
                        r_state  <= ST_RELEASE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
                    end
                end
                ST_RELEASE: begin
                    r_ptr   <= (r_mid == MID_WIDTH'(NUM_MASTERS - 1)) ? '0 : r_mid + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_m_grants    = r_grants;
    assign o_mid_current = r_mid;
    assign o_grant_valid = r_gvalid;
    assign o_state       = r_state;
    assign o_timeout_evt = r_tevt;

endmodule
